sram_like_to_axi: RTL and testbench

Bridge between the core's two sram-like ports (instruction and data) and a single AXI3/AXI4 master port. Sits directly downstream of the core-plus-sram-like wrapper: it consumes the `inst_*`/`data_*` request streams, arbitrates between them and issues one single-beat AXI transaction at a time. Each sram-like request gets exactly one `addr_ok` and one `data_ok`.

---
 rtl/axi_bridge_pkg.sv | 24 ++
 rtl/axi_wstrb_gen.sv | 21 ++
 rtl/sram_like_to_axi.sv | 217 +++++++++++++++++++++
 tb/tb_sram_like_to_axi.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the sram-like to AXI bridge.
// Defines the FSM state encoding, the request source tag and the AXI size mapping.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdAddr = 3'd1,
    StRdData = 3'd2,
    StWrReq  = 3'd3,
    StWrResp = 3'd4
  } bridge_state_e;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } bridge_src_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator for 32-bit AXI writes.
// Maps an sram-like transfer size and low address bits to wstrb.
module axi_wstrb_gen
  import axi_bridge_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wstrb
);

  always_comb begin
    o_wstrb = 4'b1111;
    unique case (i_size)
      2'd0:    o_wstrb = 4'b0001 << i_addr_lo;
      2'd1:    o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
      // Size 3 is illegal on the core side; fall back to a full word.
      default: o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_to_axi.sv
// Bridges the core's instruction and data sram-like ports onto one AXI master.
// One single-beat transaction in flight at a time; data requests win arbitration.
module sram_like_to_axi
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // Instruction sram-like port
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  // Data sram-like port
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  // AXI read address
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic [1:0]  o_arlock,
  output logic [3:0]  o_arcache,
  output logic [2:0]  o_arprot,
  output logic        o_arvalid,
  input  logic        i_arready,
  // AXI read data
  input  logic [3:0]  i_rid,
  input  logic [31:0] i_rdata,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready,
  // AXI write address
  output logic [3:0]  o_awid,
  output logic [31:0] o_awaddr,
  output logic [7:0]  o_awlen,
  output logic [2:0]  o_awsize,
  output logic [1:0]  o_awburst,
  output logic [1:0]  o_awlock,
  output logic [3:0]  o_awcache,
  output logic [2:0]  o_awprot,
  output logic        o_awvalid,
  input  logic        i_awready,
  // AXI write data
  output logic [3:0]  o_wid,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wlast,
  output logic        o_wvalid,
  input  logic        i_wready,
  // AXI write response
  input  logic [3:0]  i_bid,
  input  logic        i_bvalid,
  output logic        o_bready
);

  bridge_state_e r_state, w_state_d;
  bridge_src_e   r_src;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_aw_done, r_w_done;

  logic          w_aw_fin, w_w_fin;
  logic [3:0]    w_src_id;
  logic          w_unused;

  // IDs, response tags and the latched wr bit are not needed to steer the single outstanding
  // transaction; wr is kept only as a record of the accepted request.
  assign w_unused = ^{i_inst_wr, i_inst_wdata, i_rid, i_rlast, i_bid, r_wr};

  assign w_aw_fin = r_aw_done | i_awready;
  assign w_w_fin  = r_w_done | i_wready;
  assign w_src_id = (r_src == SRC_DATA) ? DATA_ID : INST_ID;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_data_req) begin
          w_state_d = i_data_wr ? StWrReq : StRdAddr;
        end else if (i_inst_req) begin
          w_state_d = StRdAddr;
        end
      end
      StRdAddr: if (i_arready) w_state_d = StRdData;
      StRdData: if (i_rvalid) w_state_d = StIdle;
      StWrReq:  if (w_aw_fin && w_w_fin) w_state_d = StWrResp;
      StWrResp: if (i_bvalid) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    o_inst_addr_ok = 1'b0;
    o_data_addr_ok = 1'b0;
    o_inst_data_ok = 1'b0;
    o_data_data_ok = 1'b0;
    o_arvalid      = 1'b0;
    o_rready       = 1'b0;
    o_awvalid      = 1'b0;
    o_wvalid       = 1'b0;
    o_bready       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_data_addr_ok = i_data_req;
        o_inst_addr_ok = i_inst_req & ~i_data_req;
      end
      StRdAddr: o_arvalid = 1'b1;
      StRdData: begin
        o_rready       = 1'b1;
        o_inst_data_ok = i_rvalid & (r_src == SRC_INST);
        o_data_data_ok = i_rvalid & (r_src == SRC_DATA);
      end
      StWrReq: begin
        o_awvalid = ~r_aw_done;
        o_wvalid  = ~r_w_done;
      end
      StWrResp: begin
        o_bready       = 1'b1;
        o_data_data_ok = i_bvalid;
      end
      default: ;
    endcase
  end

  // Request latch and write-channel completion flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src     <= SRC_INST;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (o_data_addr_ok) begin
        r_src   <= SRC_DATA;
        r_wr    <= i_data_wr;
        r_size  <= i_data_size;
        r_addr  <= i_data_addr;
        r_wdata <= i_data_wdata;
      end else if (o_inst_addr_ok) begin
        r_src   <= SRC_INST;
        r_wr    <= 1'b0;
        r_size  <= i_inst_size;
        r_addr  <= i_inst_addr;
        r_wdata <= 32'd0;
      end
      if (r_state != StWrReq) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (o_awvalid && i_awready) r_aw_done <= 1'b1;
        if (o_wvalid && i_wready)   r_w_done  <= 1'b1;
      end
    end
  end

  assign o_inst_rdata = i_rdata;
  assign o_data_rdata = i_rdata;

  assign o_arid    = w_src_id;
  assign o_araddr  = r_addr;
  assign o_arlen   = 8'd0;
  assign o_arsize  = axi_size(r_size);
  assign o_arburst = BURST_INCR;
  assign o_arlock  = 2'd0;
  assign o_arcache = 4'd0;
  assign o_arprot  = 3'd0;

  assign o_awid    = DATA_ID;
  assign o_awaddr  = r_addr;
  assign o_awlen   = 8'd0;
  assign o_awsize  = axi_size(r_size);
  assign o_awburst = BURST_INCR;
  assign o_awlock  = 2'd0;
  assign o_awcache = 4'd0;
  assign o_awprot  = 3'd0;

  assign o_wid   = DATA_ID;
  assign o_wdata = r_wdata;
  assign o_wlast = 1'b1;

  axi_wstrb_gen u_wstrb_gen (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .o_wstrb   (o_wstrb)
  );

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Self-checking bench for sram_like_to_axi: the bench acts as AXI slave and sram-like master,
// predicting every handshake from the bridge's protocol rules.
module tb_sram_like_to_axi;

  localparam logic [3:0] InstId = 4'd0;
  localparam logic [3:0] DataId = 4'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_like_to_axi #(.INST_ID(InstId), .DATA_ID(DataId)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst_req(inst_req), .i_inst_wr(inst_wr), .i_inst_size(inst_size),
    .i_inst_addr(inst_addr), .i_inst_wdata(inst_wdata),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
    .i_wready(wready),
    .i_bid(bid), .i_bvalid(bvalid), .o_bready(bready)
  );

  // Byte lanes covered by an aligned access of 2**size bytes.
  function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
    int nbytes;
    int first;
    if (size >= 2'd2) return 4'hf;
    nbytes = 1 << size;
    first  = (int'(addr % 4) / nbytes) * nbytes;
    return 4'(((1 << nbytes) - 1) << first);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bvalid = 0;
  endtask

  // Runs one full request; ad/wd = cycles before awready(arready)/wready, rd = response delay.
  // Called in the cycle the request is presented, returns in the first idle cycle after data_ok.
  task automatic do_txn(input bit is_data, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd_val,
                        input logic [31:0] rd_val, input int ad, input int wd, input int rd,
                        input bit hold_inst, input string name);
    logic [3:0]  exp_id;
    logic [31:0] got_rdata;
    bit          is_write, aw_seen, w_seen;
    int          n;
    exp_id   = is_data ? DataId : InstId;
    is_write = is_data && wr;
    if (is_data) begin
      data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd_val;
    end else begin
      inst_req = 1; inst_wr = 1'($urandom); inst_size = size; inst_addr = addr;
      inst_wdata = $urandom;
    end
    #1;
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== {is_data, !is_data}) begin
      errors++;
      $display("FAIL %s addr_ok: got data=%b inst=%b want data=%b inst=%b", name,
               data_addr_ok, inst_addr_ok, is_data, !is_data);
    end
    step();
    // Scramble the sram-like side so only latched values can reach the AXI payload.
    data_req = 0; data_addr = $urandom; data_wdata = $urandom; data_size = 2'($urandom);
    if (!hold_inst) inst_req = 0;
    if (!is_write) begin
      for (int c = 0; c <= ad; c++) begin
        arready = (c == ad);
        #1;
        checks++;
        if ({arvalid, araddr, arsize, arid} !== {1'b1, addr, 1'b0, size, exp_id}) begin
          errors++;
          $display("FAIL %s ar: got v=%b a=%h s=%0d id=%0d want v=1 a=%h s=%0d id=%0d", name,
                   arvalid, araddr, arsize, arid, addr, size, exp_id);
        end
        checks++;
        if ({rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok} !== 6'b0) begin
          errors++;
          $display("FAIL %s ar_phase_idle: got %b want 000000", name,
                   {rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok});
        end
        step();
      end
      arready = 0;
      for (int c = 0; c <= rd; c++) begin
        rvalid = (c == rd); rdata = (c == rd) ? rd_val : $urandom; rid = exp_id; rlast = 1;
        #1;
        got_rdata = is_data ? data_rdata : inst_rdata;
        checks++;
        if ({rready, arvalid, inst_addr_ok, data_addr_ok} !== 4'b1000) begin
          errors++;
          $display("FAIL %s r_phase: got rready=%b arvalid=%b aok=%b%b want 1 0 00", name,
                   rready, arvalid, inst_addr_ok, data_addr_ok);
        end
        checks++;
        if ({inst_data_ok, data_data_ok} !== {!is_data && c == rd, is_data && c == rd}) begin
          errors++;
          $display("FAIL %s r_data_ok: got inst=%b data=%b want inst=%b data=%b", name,
                   inst_data_ok, data_data_ok, !is_data && c == rd, is_data && c == rd);
        end
        if (c == rd) begin
          checks++;
          if (got_rdata !== rd_val) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, got_rdata, rd_val);
          end
        end
        step();
      end
      rvalid = 0;
    end else begin
      aw_seen = 0; w_seen = 0; n = 0;
      while (!(aw_seen && w_seen)) begin
        awready = (n >= ad); wready = (n >= wd);
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid} !== {!aw_seen, !w_seen, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s w_valids: got aw=%b w=%b b=%b ar=%b want aw=%b w=%b b=0 ar=0",
                   name, awvalid, wvalid, bready, arvalid, !aw_seen, !w_seen);
        end
        checks++;
        if ({awaddr, awsize, awid} !== {addr, 1'b0, size, DataId}) begin
          errors++;
          $display("FAIL %s aw_payload: got a=%h s=%0d id=%0d want a=%h s=%0d id=%0d", name,
                   awaddr, awsize, awid, addr, size, DataId);
        end
        checks++;
        if ({wdata, wstrb, wid, wlast} !== {wd_val, ref_strb(size, addr), DataId, 1'b1}) begin
          errors++;
          $display("FAIL %s w_payload: got d=%h strb=%b id=%0d last=%b want d=%h strb=%b",
                   name, wdata, wstrb, wid, wlast, wd_val, ref_strb(size, addr));
        end
        if (awready) aw_seen = 1;
        if (wready) w_seen = 1;
        step();
        n++;
        if (n > 40) begin
          errors++;
          $display("FAIL %s w_timeout: got no completion want completion in 40 cycles", name);
          break;
        end
      end
      awready = 0; wready = 0;
      for (int c = 0; c <= rd; c++) begin
        bvalid = (c == rd); bid = DataId;
        #1;
        checks++;
        if ({bready, awvalid, wvalid} !== 3'b100) begin
          errors++;
          $display("FAIL %s b_phase: got bready=%b aw=%b w=%b want 1 0 0", name, bready,
                   awvalid, wvalid);
        end
        checks++;
        if ({inst_data_ok, data_data_ok} !== {1'b0, c == rd}) begin
          errors++;
          $display("FAIL %s b_data_ok: got inst=%b data=%b want inst=0 data=%b", name,
                   inst_data_ok, data_data_ok, c == rd);
        end
        step();
      end
      bvalid = 0;
    end
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, arvalid, awvalid, wvalid, inst_addr_ok} !==
        {5'b0, hold_inst}) begin
      errors++;
      $display("FAIL %s back_to_idle: got dok=%b%b ar=%b aw=%b w=%b inst_aok=%b want inst_aok=%b",
               name, inst_data_ok, data_data_ok, arvalid, awvalid, wvalid, inst_addr_ok,
               hold_inst);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    step();
    step();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
         inst_data_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000000", {arvalid, rready, awvalid, wvalid,
               bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    checks++;
    if ({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot} !==
        {8'd0, 8'd0, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_constants: got len=%0d/%0d burst=%b/%b want len=0 burst=01", arlen,
               awlen, arburst, awburst);
    end
    checks++;
    if ({araddr, awaddr, wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_latched: got ar=%h aw=%h wd=%h want 0", araddr, awaddr, wdata);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_inst_read();
    do_txn(0, 0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C1D_BFC0, 0, 0, 0, 0, "inst_read");
  endtask

  task automatic test_stores();
    do_txn(1, 1, 2'd0, 32'h8000_0003, 32'hAAAA_AAAA, 32'h0, 0, 0, 1, 0, "byte_store");
    checks++;
    if (ref_strb(2'd0, 32'h8000_0003) !== 4'b1000) begin
      errors++;
      $display("FAIL byte_strb_model: got %b want 1000", ref_strb(2'd0, 32'h8000_0003));
    end
    do_txn(1, 1, 2'd1, 32'h8000_0002, 32'h5555_5555, 32'h0, 0, 0, 0, 0, "half_store_hi");
    do_txn(1, 1, 2'd1, 32'h8000_0000, 32'h1234_1234, 32'h0, 0, 0, 0, 0, "half_store_lo");
    do_txn(1, 1, 2'd3, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, "illegal_size_store");
  endtask

  task automatic test_aw_stall();
    do_txn(1, 1, 2'd2, 32'h8000_1000, 32'hCAFE_F00D, 32'h0, 3, 0, 2, 0, "aw_stall");
    do_txn(1, 1, 2'd2, 32'h8000_2000, 32'h0BAD_CAFE, 32'h0, 0, 2, 0, 0, "w_stall");
  endtask

  task automatic test_simultaneous();
    inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC0_0010;
    do_txn(1, 0, 2'd2, 32'h8000_0040, 32'h0, 32'h7777_0001, 1, 0, 1, 1, "simul_data");
    do_txn(0, 0, 2'd2, 32'hBFC0_0010, 32'h0, 32'h2408_0001, 0, 0, 0, 0, "simul_inst");
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
    #1;
    step();
    inst_req = 0; arready = 1;
    #1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h1111_2222;
    #1;
    checks++;
    if ({rready, inst_data_ok} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_setup: got rready=%b dok=%b want 1 1", rready, inst_data_ok);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({arvalid, rready, inst_data_ok, data_data_ok, awvalid, wvalid, bready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 0000000", {arvalid, rready, inst_data_ok,
               data_data_ok, awvalid, wvalid, bready});
    end
    step();
    rvalid = 0;
    rst_n = 1;
    do_txn(1, 0, 2'd1, 32'h8000_0302, 32'h0, 32'h9999_AAAA, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    bit          d, w;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      d  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      do_txn(d, w, sz, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 0, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inst_read();
    test_stores();
    test_aw_stall();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
